// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_ILLEGAL = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and cache port bundle for mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic                    resp_valid;
  logic [DATA_W-1:0]       resp_rdata;
  logic [1:0]              resp_err;
  logic                    busy;
  logic                    cache_en;
  logic                    cache_write_en;
  logic [ADDR_W-1:0]       cache_addr;
  logic [BYTES-1:0][7:0]   cache_data_in;
  logic [BYTES-1:0][7:0]   cache_data_out;
  logic                    hit;

  // Environment side: pipeline plus cache.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           cache_data_out, hit,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           cache_en, cache_write_en, cache_addr, cache_data_in
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           cache_data_out, hit,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           cache_en, cache_write_en, cache_addr, cache_data_in
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane merge for partial stores and lane extract/extend for loads.
// Lanes are big-endian: lane k sits at packed element BYTES-1-k.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BYTES  = DATA_W / 8,
  localparam int unsigned OFS_W  = $clog2(BYTES)
) (
  input  logic [1:0]            i_size,
  input  logic [OFS_W-1:0]      i_ofs,
  input  logic                  i_signed,
  input  logic [BYTES-1:0][7:0] i_word,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [BYTES-1:0][7:0] o_merged_c,
  output logic [DATA_W-1:0]     o_rdata_c
);

  logic [OFS_W-1:0] w_lane;
  logic [OFS_W-1:0] w_hlane;
  logic [OFS_W-1:0] w_hlane_lo;
  logic [7:0]       w_b;
  logic [15:0]      w_h;

  always_comb begin
    w_lane     = OFS_W'(BYTES - 1) - i_ofs;
    w_hlane    = OFS_W'(BYTES - 1) - (i_ofs & ~OFS_W'(1));
    w_hlane_lo = w_hlane - OFS_W'(1);
    w_b        = i_word[w_lane];
    w_h        = {i_word[w_hlane], i_word[w_hlane_lo]};

    o_merged_c = i_word;
    o_rdata_c  = i_word;
    unique case (i_size)
      SZ_BYTE: begin
        o_merged_c[w_lane] = i_wdata[7:0];
        o_rdata_c = i_signed ? DATA_W'($signed(w_b)) : DATA_W'(w_b);
      end
      SZ_HALF: begin
        o_merged_c[w_hlane]    = i_wdata[15:8];
        o_merged_c[w_hlane_lo] = i_wdata[7:0];
        o_rdata_c = i_signed ? DATA_W'($signed(w_h)) : DATA_W'(w_h);
      end
      default: begin
        o_merged_c = i_wdata;
        o_rdata_c  = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: validates requests, runs read-modify-write for
// partial stores and aborts cache accesses that miss for too long.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MISS_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  mem_access_unit_if.slave bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);
  localparam int unsigned CNT_W = $clog2(MISS_TIMEOUT + 1);

  state_e                r_state;
  state_e                w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nx;
  err_e                  w_err_nx;

  logic [ADDR_W-1:0]     r_cache_addr;
  logic [OFS_W-1:0]      r_ofs;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_write;
  logic [DATA_W-1:0]     r_wdata;
  logic [BYTES-1:0][7:0] r_wword;
  logic [DATA_W-1:0]     r_rdata;
  err_e                  r_err;
  logic                  r_resp_valid;
  logic                  r_cache_en;
  logic                  r_cache_we;
  logic                  r_busy;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_misalign;
  logic [BYTES-1:0][7:0] w_merged_c;
  logic [DATA_W-1:0]     w_rdata_c;

  assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
  assign w_misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_WORD) && (bus.req_addr[OFS_W-1:0] != '0));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size     (r_size),
    .i_ofs      (r_ofs),
    .i_signed   (r_signed),
    .i_word     (bus.cache_data_out),
    .i_wdata    (r_wdata),
    .o_merged_c (w_merged_c),
    .o_rdata_c  (w_rdata_c)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state, miss counter and error code.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_err_nx   = ERR_NONE;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (bus.req_valid) begin
          if (bus.req_size == SZ_ILLEGAL) begin
            w_state_nx = ST_ERR;
            w_err_nx   = ERR_ILLEGAL;
          end else if (w_misalign) begin
            w_state_nx = ST_ERR;
            w_err_nx   = ERR_ALIGN;
          end else if (!bus.req_write || (bus.req_size != SZ_WORD)) begin
            w_state_nx = ST_READ;
          end else begin
            w_state_nx = ST_WRITE;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (bus.hit) begin
          w_cnt_nx   = '0;
          w_state_nx = ((r_state == ST_READ) && r_write) ? ST_WRITE : ST_DONE;
        end else if (r_cnt == CNT_W'(MISS_TIMEOUT - 1)) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_ERR;
          w_err_nx   = ERR_TIMEOUT;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERR: w_state_nx = ST_IDLE;
      default:         w_state_nx = ST_IDLE;
    endcase
  end

  // Request capture, datapath and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cache_addr <= '0;
      r_ofs        <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_wword      <= '0;
      r_rdata      <= '0;
      r_err        <= ERR_NONE;
      r_resp_valid <= 1'b0;
      r_cache_en   <= 1'b0;
      r_cache_we   <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      if (w_accept) begin
        r_cache_addr <= {bus.req_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
        r_ofs        <= bus.req_addr[OFS_W-1:0];
        r_size       <= bus.req_size;
        r_signed     <= bus.req_signed;
        r_write      <= bus.req_write;
        r_wdata      <= bus.req_wdata;
        r_wword      <= bus.req_wdata;
      end else if ((r_state == ST_READ) && bus.hit) begin
        r_wword <= w_merged_c;
      end
      r_rdata      <= ((r_state == ST_READ) && bus.hit && !r_write) ? w_rdata_c : '0;
      r_err        <= w_err_nx;
      r_resp_valid <= (w_state_nx == ST_DONE) || (w_state_nx == ST_ERR);
      r_cache_en   <= (w_state_nx == ST_READ) || (w_state_nx == ST_WRITE);
      r_cache_we   <= (w_state_nx == ST_WRITE);
      r_busy       <= (w_state_nx != ST_IDLE);
      r_ready      <= (w_state_nx == ST_IDLE);
    end
  end

  assign bus.req_ready      = r_ready;
  assign bus.busy           = r_busy;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_rdata;
  assign bus.resp_err       = r_err;
  assign bus.cache_en       = r_cache_en;
  assign bus.cache_write_en = r_cache_we;
  assign bus.cache_addr     = r_cache_addr;
  assign bus.cache_data_in  = r_wword;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small cache model and a
// scoreboard of expected responses.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned MISS_TIMEOUT = 16;
  localparam int          NEVER_HIT    = 1000;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MISS_TIMEOUT(MISS_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  // Cache model: one word per 4 KiB page, hit after miss_cfg consecutive enabled cycles.
  logic [31:0] mem [16];
  int          miss_cfg   = 0;
  int          acc_cyc    = 0;
  int          en_cycles  = 0;
  int          wr_cycles  = 0;
  logic        pl_valid   = 1'b0;
  logic [3:0]  pl_idx     = '0;
  logic [31:0] pl_data    = '0;

  assign bus.hit            = bus.cache_en && (acc_cyc >= miss_cfg);
  assign bus.cache_data_out = mem[bus.cache_addr[15:12]];

  always @(posedge clk) begin
    acc_cyc <= bus.cache_en ? acc_cyc + 1 : 0;
    if (bus.cache_en) en_cycles <= en_cycles + 1;
    if (pl_valid) mem[pl_idx] <= pl_data;
    else if (bus.cache_en && bus.cache_write_en && bus.hit) begin
      mem[bus.cache_addr[15:12]] <= bus.cache_data_in;
      wr_cycles <= wr_cycles + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_valid = 1'b1;
    pl_idx   = idx;
    pl_data  = data;
    @(posedge clk);
    #1 pl_valid = 1'b0;
  endtask

  // Drive one request (called #1 after a posedge) and score its response.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input int miss, input logic [31:0] e_rdata, input logic [1:0] e_err,
                         input int e_lat, input logic chk_busy,
                         output int n_en, output int n_wr);
    exp_t e;
    int   lat;
    int   en0, wr0;
    logic busy_ok;
    sb.push_back('{rdata: e_rdata, err: e_err, lat: e_lat});
    check_eq({tag, ".ready"}, 64'(bus.req_ready), 64'(1));
    miss_cfg       = miss;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    en0 = en_cycles;
    wr0 = wr_cycles;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.resp_valid && lat < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    e = sb.pop_front();
    check_eq({tag, ".lat"},   64'(lat),            64'(e.lat));
    check_eq({tag, ".rdata"}, 64'(bus.resp_rdata), 64'(e.rdata));
    check_eq({tag, ".err"},   64'(bus.resp_err),   64'(e.err));
    if (chk_busy) check_eq({tag, ".busy"}, 64'(busy_ok), 64'(1));
    @(posedge clk);
    #1;
    check_eq({tag, ".ready_after"}, 64'(bus.req_ready), 64'(1));
    check_eq({tag, ".valid_drop"},  64'(bus.resp_valid), 64'(0));
    n_en = en_cycles - en0;
    n_wr = wr_cycles - wr0;
  endtask

  int n_en, n_wr;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #1;
    check_eq("rst.valid",  64'(bus.resp_valid), 64'(0));
    check_eq("rst.busy",   64'(bus.busy),       64'(0));
    check_eq("rst.en",     64'(bus.cache_en),   64'(0));
    check_eq("rst.rdata",  64'(bus.resp_rdata), 64'(0));
    check_eq("rst.err",    64'(bus.resp_err),   64'(ERR_NONE));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;

    preload(4'h1, 32'h11F2_3344);
    preload(4'h2, 32'hAABB_CCDD);
    preload(4'h3, 32'h0102_0304);
    preload(4'h5, 32'h5555_AAAA);
    preload(4'h6, 32'h6666_6666);
    preload(4'h7, 32'h5566_7788);
    preload(4'h9, 32'h9999_9999);

    run_req("lb_s", 1'b0, SZ_BYTE, 1'b1, 32'h1001, '0, 0, 32'hFFFF_FFF2, ERR_NONE, 2, 1'b1, n_en, n_wr);
    run_req("lhu_miss", 1'b0, SZ_HALF, 1'b0, 32'h2002, '0, 3, 32'h0000_CCDD, ERR_NONE, 5, 1'b1, n_en, n_wr);
    run_req("sb", 1'b1, SZ_BYTE, 1'b0, 32'h3003, 32'h0000_00EE, 0, '0, ERR_NONE, 3, 1'b1, n_en, n_wr);
    check_eq("sb.writes", 64'(n_wr), 64'(1));
    check_eq("sb.mem",    64'(mem[3]), 64'(32'h0102_03EE));
    run_req("lw_back", 1'b0, SZ_WORD, 1'b0, 32'h3000, '0, 0, 32'h0102_03EE, ERR_NONE, 2, 1'b0, n_en, n_wr);

    run_req("lw_align", 1'b0, SZ_WORD, 1'b0, 32'h4002, '0, 0, '0, ERR_ALIGN, 1, 1'b0, n_en, n_wr);
    check_eq("lw_align.no_cache", 64'(n_en), 64'(0));
    run_req("illegal", 1'b0, SZ_ILLEGAL, 1'b0, 32'h4000, '0, 0, '0, ERR_ILLEGAL, 1, 1'b0, n_en, n_wr);
    check_eq("illegal.no_cache", 64'(n_en), 64'(0));
    run_req("lh_align", 1'b0, SZ_HALF, 1'b1, 32'h4001, '0, 0, '0, ERR_ALIGN, 1, 1'b0, n_en, n_wr);

    run_req("sw_tmo", 1'b1, SZ_WORD, 1'b0, 32'h6000, 32'hCAFE_F00D, NEVER_HIT, '0, ERR_TIMEOUT,
            MISS_TIMEOUT + 1, 1'b1, n_en, n_wr);
    check_eq("sw_tmo.en_cycles", 64'(n_en), 64'(MISS_TIMEOUT));
    check_eq("sw_tmo.mem", 64'(mem[6]), 64'(32'h6666_6666));

    run_req("sh", 1'b1, SZ_HALF, 1'b0, 32'h7000, 32'h1234_ABCD, 0, '0, ERR_NONE, 3, 1'b0, n_en, n_wr);
    check_eq("sh.mem", 64'(mem[7]), 64'(32'hABCD_7788));
    run_req("lh_s", 1'b0, SZ_HALF, 1'b1, 32'h7000, '0, 0, 32'hFFFF_ABCD, ERR_NONE, 2, 1'b0, n_en, n_wr);
    run_req("lbu", 1'b0, SZ_BYTE, 1'b0, 32'h7003, '0, 0, 32'h0000_0088, ERR_NONE, 2, 1'b0, n_en, n_wr);
    run_req("sw", 1'b1, SZ_WORD, 1'b0, 32'h8000, 32'hDEAD_BEEF, 0, '0, ERR_NONE, 2, 1'b0, n_en, n_wr);
    check_eq("sw.mem", 64'(mem[8]), 64'(32'hDEAD_BEEF));
    run_req("sb_tmo", 1'b1, SZ_BYTE, 1'b0, 32'h9002, 32'h0000_0011, NEVER_HIT, '0, ERR_TIMEOUT,
            MISS_TIMEOUT + 1, 1'b0, n_en, n_wr);
    check_eq("sb_tmo.writes", 64'(n_wr), 64'(0));
    check_eq("sb_tmo.mem", 64'(mem[9]), 64'(32'h9999_9999));

    // Asynchronous reset in the middle of a missing full-word store.
    miss_cfg       = NEVER_HIT;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h5000;
    bus.req_wdata  = 32'h0BAD_0BAD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("arst.pre_we", 64'(bus.cache_write_en), 64'(1));
    #2 rst_b = 1'b0;
    #1;
    check_eq("arst.en",    64'(bus.cache_en),       64'(0));
    check_eq("arst.we",    64'(bus.cache_write_en), 64'(0));
    check_eq("arst.busy",  64'(bus.busy),           64'(0));
    check_eq("arst.ready", 64'(bus.req_ready),      64'(1));
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;
    run_req("lw_post_rst", 1'b0, SZ_WORD, 1'b0, 32'h5000, '0, 0, 32'h5555_AAAA, ERR_NONE, 2, 1'b0, n_en, n_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
